// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Holds the decoded instruction for one cycle and presents post-forwarding
// operands to the ALU. A load in EX whose destination is read by the
// instruction in ID stalls ID for one cycle and sends a bubble into EX.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_alu_src,
    input  logic [2:0]         id_alu_ctrl,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               flush,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]    memwb_wdata,
    output logic               stall_id,
    output logic               ex_valid,
    output logic [2:0]         ex_alu_ctrl,
    output logic [XLEN-1:0]    ex_a,
    output logic [XLEN-1:0]    ex_b,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);

    logic [RADDR_W-1:0] rs1_q;
    logic [RADDR_W-1:0] rs2_q;
    logic [XLEN-1:0]    rs1_data_q;
    logic [XLEN-1:0]    rs2_data_q;
    logic [XLEN-1:0]    imm_q;
    logic               alu_src_q;
    logic               load_use;
    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;

    // Load in EX feeding a source of the instruction in ID; rs2 is compared
    // even when ID uses the immediate, which only costs an occasional stall.
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    assign stall_id = load_use;

    // Pipeline register: a flush or a load-use stall loads an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_alu_ctrl  <= 3'b000;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            alu_src_q    <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
        end else if (flush || load_use) begin
            ex_valid     <= 1'b0;
            ex_alu_ctrl  <= 3'b000;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            alu_src_q    <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
        end else begin
            ex_valid     <= id_valid;
            ex_alu_ctrl  <= id_alu_ctrl;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
            alu_src_q    <= id_alu_src;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
        end
    end

    // rs1 bypass: youngest producer (EX/MEM) wins; x0 always reads the regfile copy.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
            fwd_rs1 = memwb_wdata;
        end
    end

    // rs2 bypass, shared by the ALU B operand and the store data path.
    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
            fwd_rs2 = memwb_wdata;
        end
    end

    assign ex_a          = fwd_rs1;
    assign ex_store_data = fwd_rs2;
    assign ex_b          = alu_src_q ? imm_q : fwd_rs2;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed hazard scenarios followed
// by randomized traffic, checked against a behavioural model of the stage.
module tb_id_ex_operand_stage;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we;
        logic        mr;
        logic        mw;
        logic        stall;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [2:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_wdata;
    logic        stall_id, ex_valid;
    logic [2:0]  ex_alu_ctrl;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Behavioural picture of the instruction sitting in EX.
    logic        m_valid, m_src, m_we, m_mr, m_mw;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_d1, m_d2, m_imm;

    id_ex_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a source register should read: scan writers from youngest to oldest.
    function automatic logic [31:0] ref_value(input logic [4:0] idx, input logic [31:0] regval);
        logic        w_we[2];
        logic [4:0]  w_rd[2];
        logic [31:0] w_d[2];
        w_we[0] = exmem_reg_write; w_rd[0] = exmem_rd; w_d[0] = exmem_result;
        w_we[1] = memwb_reg_write; w_rd[1] = memwb_rd; w_d[1] = memwb_wdata;
        if (idx == 5'd0) return regval;
        for (int k = 0; k < 2; k++)
            if (w_we[k] && w_rd[k] == idx) return w_d[k];
        return regval;
    endfunction

    function automatic logic ref_stall();
        return m_valid && m_mr && (m_rd != 5'd0) && id_valid &&
               ((m_rd == id_rs1) || (m_rd == id_rs2));
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.valid = m_valid;
        e.ctrl  = m_ctrl;
        e.a     = ref_value(m_rs1, m_d1);
        e.sd    = ref_value(m_rs2, m_d2);
        e.b     = m_src ? m_imm : e.sd;
        e.rd    = m_rd;
        e.we    = m_we;
        e.mr    = m_mr;
        e.mw    = m_mw;
        e.stall = ref_stall();
        return e;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_src = 0; m_we = 0; m_mr = 0; m_mw = 0; m_ctrl = 0;
        m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    endtask

    task automatic model_edge();
        if (flush || ref_stall()) begin
            model_clear();
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_alu_ctrl;
            m_rd    = id_rd;
            m_we    = id_reg_write && id_valid;
            m_mr    = id_mem_read && id_valid;
            m_mw    = id_mem_write && id_valid;
            m_src   = id_alu_src;
            m_rs1   = id_rs1;
            m_rs2   = id_rs2;
            m_d1    = id_rs1_data;
            m_d2    = id_rs2_data;
            m_imm   = id_imm;
        end
    endtask

    task automatic quiet();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_alu_src = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    task automatic rand_inputs();
        id_valid        = ($urandom_range(0, 7) != 0);
        id_rs1          = 5'($urandom_range(0, 7));
        id_rs2          = 5'($urandom_range(0, 7));
        id_rd           = 5'($urandom_range(0, 7));
        id_rs1_data     = $urandom;
        id_rs2_data     = $urandom;
        id_imm          = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
        id_alu_src      = 1'($urandom_range(0, 1));
        id_alu_ctrl     = 3'($urandom_range(0, 7));
        id_reg_write    = 1'($urandom_range(0, 1));
        id_mem_read     = ($urandom_range(0, 2) == 0);
        id_mem_write    = ($urandom_range(0, 3) == 0);
        flush           = ($urandom_range(0, 7) == 0);
        exmem_reg_write = 1'($urandom_range(0, 1));
        exmem_rd        = 5'($urandom_range(0, 7));
        exmem_result    = $urandom;
        memwb_reg_write = 1'($urandom_range(0, 1));
        memwb_rd        = 5'($urandom_range(0, 7));
        memwb_wdata     = $urandom;
    endtask

    // Inputs are already applied (just after a falling edge). Optionally pulse
    // reset between edges, queue the expected outputs, then take one rising edge.
    task automatic step(input bit do_rst);
        if (do_rst) begin
            rst_n = 1'b0;
            model_clear();
        end
        #1;
        sb.push_back(predict());
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_valid",      32'(ex_valid),      32'(e.valid));
                chk("ex_alu_ctrl",   32'(ex_alu_ctrl),   32'(e.ctrl));
                chk("ex_a",          ex_a,               e.a);
                chk("ex_b",          ex_b,               e.b);
                chk("ex_store_data", ex_store_data,      e.sd);
                chk("ex_rd",         32'(ex_rd),         32'(e.rd));
                chk("ex_reg_write",  32'(ex_reg_write),  32'(e.we));
                chk("ex_mem_read",   32'(ex_mem_read),   32'(e.mr));
                chk("ex_mem_write",  32'(ex_mem_write),  32'(e.mw));
                chk("stall_id",      32'(stall_id),      32'(e.stall));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        quiet();
        model_clear();
        @(negedge clk);

        // reset holds everything at zero even with live ID inputs
        rand_inputs();
        step(1);

        // capture: rs1=1 (5), rs2=2 (7), add, register B
        quiet();
        id_valid = 1; id_rs1 = 1; id_rs1_data = 5; id_rs2 = 2; id_rs2_data = 7; id_rd = 9;
        step(0);
        quiet();
        step(0);

        // EX/MEM beats MEM/WB, then MEM/WB alone
        quiet(); id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h33;
        step(0);
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h10;
        memwb_reg_write = 1; memwb_rd = 3; memwb_wdata = 32'h20;
        step(0);
        exmem_reg_write = 0;
        step(0);

        // x0 never forwarded
        quiet(); id_valid = 1; id_rs1 = 0; id_rs2 = 0;
        step(0);
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFF;
        memwb_reg_write = 1; memwb_rd = 0; memwb_wdata = 32'hEE;
        step(0);

        // load-use: lw x5 then a consumer of x5 in rs2
        quiet(); id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1;
        step(0);
        quiet(); id_valid = 1; id_rs1 = 6; id_rs2 = 5; id_rs2_data = 32'h1111; id_rd = 7;
        id_reg_write = 1; id_alu_ctrl = 3'b111;
        step(0);
        step(0);
        quiet(); memwb_reg_write = 1; memwb_rd = 5; memwb_wdata = 32'hCAFE_0005;
        step(0);

        // flush coinciding with a stall, then immediate path
        quiet(); id_valid = 1; id_rd = 4; id_mem_read = 1; id_reg_write = 1;
        step(0);
        quiet(); id_valid = 1; id_rs1 = 4; flush = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
        step(0);
        quiet(); id_valid = 1; id_rs2 = 8; id_rs2_data = 32'h88; id_alu_src = 1;
        id_imm = 32'hFFFF_FFFC; id_mem_write = 1;
        step(0);
        quiet(); memwb_reg_write = 1; memwb_rd = 8; memwb_wdata = 32'h8080_8080;
        step(0);

        // asynchronous reset between edges with a valid instruction in EX
        quiet(); id_valid = 1; id_rs1 = 2; id_rs1_data = 32'h1234; id_rd = 3;
        id_reg_write = 1; id_mem_read = 1; id_alu_ctrl = 3'b101;
        step(0);
        step(1);
        step(0);

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step($urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
